// File: rtl/ifu_defs_pkg.sv
// ---------------------------------------------------------------------------
// ifu_defs: constants shared by the fetch unit and its F/D pipeline register.
//   PC_RESET     fetch PC after reset
//   EXC_HANDLER  fetch PC on exception/interrupt entry
//   EXC_NONE     F/D exception code: no exception
//   EXC_ADEL     F/D exception code: instruction-fetch address error
// ---------------------------------------------------------------------------
package ifu_defs;

    localparam logic [31:0] PC_RESET    = 32'h0000_3000;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam logic [4:0]  EXC_NONE    = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;

    // Sequential fetch step; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fd_reg.sv
// ---------------------------------------------------------------------------
// fd_reg: F/D pipeline register between fetch and decode.
//   clk, reset   clock, synchronous active-high reset
//   en           capture enable (low while the pipeline is stalled)
//   flush        replace the captured instruction with a bubble; wins over en
//   flush_pc     PC recorded alongside the bubble
//   pc_in        fetch PC being captured
//   instr_in     instruction word returned for pc_in
//   adel_in      fetch address error for pc_in
//   bd_in        captured instruction sits in a branch delay slot
//   d_instr/d_pc/d_exc/d_bd  registered outputs toward decode
// ---------------------------------------------------------------------------
module fd_reg
    import ifu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        adel_in,
    input  logic        bd_in,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exc,
    output logic        d_bd
);

    logic [31:0] d_instr_reg;
    logic [31:0] d_pc_reg;
    logic [4:0]  d_exc_reg;
    logic        d_bd_reg;

    // A faulting fetch must not hand a garbage word to decode: force it to
    // zero (a nop) so only the exception code carries meaning.
    logic [31:0] instr_gated;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_instr_gate
            assign instr_gated[gi] = instr_in[gi] & ~adel_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr_reg <= 32'd0;
            d_pc_reg    <= RESET_PC;
            d_exc_reg   <= EXC_NONE;
            d_bd_reg    <= 1'b0;
        end else if (flush) begin
            d_instr_reg <= 32'd0;
            d_pc_reg    <= flush_pc;
            d_exc_reg   <= EXC_NONE;
            d_bd_reg    <= 1'b0;
        end else if (en) begin
            d_instr_reg <= instr_gated;
            d_pc_reg    <= pc_in;
            d_exc_reg   <= adel_in ? EXC_ADEL : EXC_NONE;
            d_bd_reg    <= bd_in;
        end
    end

    assign d_instr = d_instr_reg;
    assign d_pc    = d_pc_reg;
    assign d_exc   = d_exc_reg;
    assign d_bd    = d_bd_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit: owns the fetch PC, drives it to instruction memory and
// captures the returned word (plus fetch-error flag) into the F/D register.
// Next-PC priority: reset > req > eret_d > stall > redirect > f_pc+4.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   f_pc              fetch PC to instruction memory
//   im_instr, im_adel combinational IM response for f_pc
//   stall             hold PC and F/D register
//   redirect/redirect_pc  taken branch / jump target from D
//   d_is_jump         D holds a branch/jump (next fetch is its delay slot)
//   eret_d, epc       eret in D, return address from CP0
//   req               exception/interrupt accepted at M
//   d_instr, d_pc, d_exc, d_bd  F/D register outputs
//
// Build option: define IFU_BD_TRACK_EN to capture d_bd from d_is_jump;
// otherwise d_bd is constant 0 and d_is_jump is ignored.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET    = ifu_defs::PC_RESET,
    parameter logic [31:0] EXC_HANDLER = ifu_defs::EXC_HANDLER
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] f_pc,
    input  logic [31:0] im_instr,
    input  logic        im_adel,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        d_is_jump,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        req,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exc,
    output logic        d_bd
);

    import ifu_defs::*;

    logic [31:0] f_pc_reg;
    logic [31:0] f_pc_next;
    logic        fd_flush;
    logic [31:0] fd_flush_pc;
    logic        bd_capture;

    // req and eret_d override a stall: both discard what is in flight and
    // vector fetch elsewhere. A redirect during a stall is dropped because
    // D keeps presenting it until the stall clears.
    always_comb begin
        f_pc_next = pc_plus4(f_pc_reg);
        if (req) begin
            f_pc_next = EXC_HANDLER;
        end else if (eret_d) begin
            f_pc_next = epc;
        end else if (stall) begin
            f_pc_next = f_pc_reg;
        end else if (redirect) begin
            f_pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_reg <= PC_RESET;
        end else begin
            f_pc_reg <= f_pc_next;
        end
    end

    assign f_pc = f_pc_reg;

    // eret has no delay slot, so the word fetched alongside it is squashed.
    assign fd_flush    = req | eret_d;
    assign fd_flush_pc = req ? EXC_HANDLER : epc;

`ifdef IFU_BD_TRACK_EN
    assign bd_capture = d_is_jump;
`else
    // Tracking disabled: the AND keeps d_is_jump formally connected.
    assign bd_capture = d_is_jump & 1'b0;
`endif

    fd_reg #(
        .RESET_PC (PC_RESET)
    ) u_fd_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (~stall),
        .flush    (fd_flush),
        .flush_pc (fd_flush_pc),
        .pc_in    (f_pc_reg),
        .instr_in (im_instr),
        .adel_in  (im_adel),
        .bd_in    (bd_capture),
        .d_instr  (d_instr),
        .d_pc     (d_pc),
        .d_exc    (d_exc),
        .d_bd     (d_bd)
    );

endmodule
